// File: rtl/csa_resolver_if.sv
// Handshake bundle between the CSA resolver and its producer/consumer.
// Input side: in_valid/in_ready carry a (sum_in, cout_in) carry-save pair.
// Output side: out_valid/out_ready carry the resolved binary result.
interface csa_resolver_if #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] cout_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] result;
  logic [CNT_W-1:0] iters;

  // Resolver side
  modport slave (
    input  in_valid,
    input  sum_in,
    input  cout_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output iters
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output sum_in,
    output cout_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  iters
  );
endinterface

// File: rtl/csa_resolver.sv
// Sequential carry-propagate resolver for a carry-save (cout, sum) pair.
// Repeats the half-adder step s' = s ^ c, c' = (s & c) << 1 until the carry
// vector is empty; the sum register then holds sum_in + (cout_in << 1).
// Latency is data dependent, bounded by WIDTH+1 iterations.
module csa_resolver #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  csa_resolver_if.slave   bus
);

  // Two guard bits: the sum of a WIDTH-bit value and a doubled WIDTH-bit value
  // is below 2^(WIDTH+2), so the carry shift never drops a bit.
  localparam int unsigned RW = WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    s_q, s_d;
  logic [RW-1:0]    c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RW-1:0]    s_iter;
  logic [RW-1:0]    c_iter;

  // One half-adder resolve step on the current register contents
  assign s_iter = s_q ^ c_q;
  assign c_iter = (s_q & c_q) << 1;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          s_d     = {2'b00, bus.sum_in};
          c_d     = {1'b0, bus.cout_in, 1'b0};
          cnt_d   = '0;
          state_d = (bus.cout_in == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        s_d   = s_iter;
        c_d   = c_iter;
        cnt_d = cnt_q + CNT_W'(1);
        if (c_iter == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs come straight from registers
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = s_q;
  assign bus.iters     = cnt_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed plan items plus random
// operand pairs checked against an integer reference model.
module tb_csa_resolver;
  localparam int unsigned WIDTH = 19;
  localparam int unsigned CNT_W = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  csa_resolver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  csa_resolver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum; iteration count from the half-adder rule
  // applied to plain integers until no carry remains.
  task automatic ref_model(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] cv,
                           output longint unsigned res, output int k);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    res = longint'(sv) + (longint'(cv) * 2);
    a = longint'(sv);
    b = longint'(cv) * 2;
    k = 0;
    while (b != 0) begin
      t = a ^ b;
      b = (a & b) * 2;
      a = t;
      k++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, measure latency, optional stall, drain.
  task automatic do_op(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] cv,
                       input int stall, input string tag);
    longint unsigned er;
    int ek;
    int lat;
    ref_model(sv, cv, er, ek);
    lat = 0;
    while (!bus.in_ready && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.sum_in    = sv;
    bus.cout_in   = cv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(ek));
    chk({tag, "_result"}, 64'(bus.result), er);
    chk({tag, "_iters"}, 64'(bus.iters), 64'(ek));
    chk({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_stall_result"}, 64'(bus.result), er);
      chk({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_idle_hold"}, 64'(bus.result), er);
  endtask

  initial begin
    longint unsigned er_a;
    longint unsigned er_b;
    int ek_a;
    int ek_b;
    int lat;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rc;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sum_in    = '0;
    bus.cout_in   = '0;
    bus.out_ready = 1'b0;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_iters", 64'(bus.iters), 64'd0);
    step();
    reset = 1'b0;
    step();

    // Reset mid-RUN
    bus.sum_in   = 19'h7FFFF;
    bus.cout_in  = 19'h00001;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("midrun_busy", 64'(bus.in_ready), 64'd0);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midrun_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrun_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_result", 64'(bus.result), 64'd0);
    chk("midrun_iters", 64'(bus.iters), 64'd0);
    step();
    reset = 1'b0;
    do_op(19'h00003, 19'h00001, 0, "after_rst");

    // Directed plan items
    do_op(19'h00005, 19'h00000, 0, "bypass");
    chk("bypass_const", 64'(bus.result), 64'h00005);
    do_op(19'h00001, 19'h00001, 0, "single");
    chk("single_const", 64'(bus.result), 64'h000003);
    chk("single_iters", 64'(bus.iters), 64'd1);
    do_op(19'h7FFFF, 19'h7FFFF, 0, "full");
    chk("full_const", 64'(bus.result), 64'h17FFFD);
    chk("full_bit20", 64'(bus.result[WIDTH+1]), 64'd1);
    do_op(19'h7FFFF, 19'h00001, 0, "chain");
    chk("chain_const", 64'(bus.result), 64'h080001);
    chk("chain_iters", 64'(bus.iters), 64'd19);

    // Backpressure with a second pair waiting at the input
    ref_model(19'h2B5A3, 19'h1C3F7, er_a, ek_a);
    ref_model(19'h0F0F0, 19'h70F0F, er_b, ek_b);
    bus.sum_in   = 19'h2B5A3;
    bus.cout_in  = 19'h1C3F7;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_a_latency", 64'(lat), 64'(ek_a));
    bus.sum_in   = 19'h0F0F0;
    bus.cout_in  = 19'h70F0F;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_result", 64'(bus.result), er_a);
      chk("bp_hold_iters", 64'(bus.iters), 64'(ek_a));
      chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_idle_result", 64'(bus.result), er_a);
    step();
    bus.in_valid = 1'b0;
    chk("bp_b_accepted", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_b_latency", 64'(lat), 64'(ek_b));
    chk("bp_b_result", 64'(bus.result), er_b);
    chk("bp_b_iters", 64'(bus.iters), 64'(ek_b));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Random operand pairs with random output stalls
    for (int n = 0; n < 30; n++) begin
      rs = WIDTH'($urandom);
      rc = WIDTH'($urandom);
      if (n % 5 == 0) rc = '0;
      do_op(rs, rc, int'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
